sh_dbus_arbiter: RTL

//  Two-master arbiter for the on-chip data bus (DBUS). It shares the bus between the CPU path
//  (cache IBUS, M0) and the DMAC (M1); one slave port drives the BSC and on-chip peripherals.

---
 rtl/sh_dbus_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sh_dbus_arbiter.sv
// Two-master DBUS arbiter: CPU path (M0) and DMAC (M1) share one slave port.
// Round-robin or fixed-priority arbitration, with bounded LOCK retention.
module sh_dbus_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned LOCK_MAX   = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic [31:0] M0_A,
  input  logic [31:0] M0_DI,
  output logic [31:0] M0_DO,
  input  logic [3:0]  M0_BA,
  input  logic        M0_WE,
  input  logic        M0_REQ,
  input  logic        M0_LOCK,
  output logic        M0_BUSY,
  output logic        M0_GNT,
  input  logic [31:0] M1_A,
  input  logic [31:0] M1_DI,
  output logic [31:0] M1_DO,
  input  logic [3:0]  M1_BA,
  input  logic        M1_WE,
  input  logic        M1_REQ,
  input  logic        M1_LOCK,
  output logic        M1_BUSY,
  output logic        M1_GNT,
  output logic [31:0] S_A,
  output logic [31:0] S_DO,
  input  logic [31:0] S_DI,
  output logic [3:0]  S_BA,
  output logic        S_WE,
  output logic        S_REQ,
  output logic        S_LOCK,
  input  logic        S_BUSY
);

  localparam int unsigned CntW = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;
  localparam logic [CntW-1:0] LimMax = CntW'(LOCK_MAX);
  localparam logic [CntW-1:0] LimM1  = CntW'((LOCK_MAX > 0) ? LOCK_MAX - 1 : 0);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;  // 1: M1 was the last owner
  logic [CntW-1:0] cnt_q, cnt_d;

  logic own_req, own_lock, oth_req, rearb;

  assign own_req  = (state_q == StOwn1) ? M1_REQ  : M0_REQ;
  assign own_lock = (state_q == StOwn1) ? M1_LOCK : M0_LOCK;
  assign oth_req  = (state_q == StOwn1) ? M0_REQ  : M1_REQ;

  function automatic state_e arbitrate(input logic r0, input logic r1, input logic last1);
    state_e res;
    if (r0 && r1) begin
      res = ((FIXED_PRIO != 0) || !last1) ? StOwn1 : StOwn0;
    end else if (r0) begin
      res = StOwn0;
    end else if (r1) begin
      res = StOwn1;
    end else begin
      res = StIdle;
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rearb   = 1'b0;
    case (state_q)
      StIdle: state_d = arbitrate(M0_REQ, M1_REQ, last_q);
      default: begin
        if (own_req && !S_BUSY) begin
          if (own_lock && (!oth_req || (LOCK_MAX == 0) || (cnt_q < LimM1))) begin
            cnt_d = (cnt_q >= LimMax) ? LimMax : cnt_q + 1'b1;
          end else begin
            rearb = 1'b1;
          end
        end else if (!own_req && !own_lock) begin
          rearb = 1'b1;
        end
        // A locked owner that has dropped REQ keeps the bus with the counter frozen.
        if (rearb) begin
          last_d  = (state_q == StOwn1);
          cnt_d   = '0;
          state_d = arbitrate(M0_REQ, M1_REQ, state_q == StOwn1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else if (CE_R) begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign M0_GNT = (state_q == StOwn0);
  assign M1_GNT = (state_q == StOwn1);
  assign M0_DO  = S_DI;
  assign M1_DO  = S_DI;

  always_comb begin
    S_A     = '0;
    S_DO    = '0;
    S_BA    = '0;
    S_WE    = 1'b0;
    S_REQ   = 1'b0;
    S_LOCK  = 1'b0;
    M0_BUSY = M0_REQ;
    M1_BUSY = M1_REQ;
    case (state_q)
      StOwn0: begin
        S_A     = M0_A;
        S_DO    = M0_DI;
        S_BA    = M0_BA;
        S_WE    = M0_WE;
        S_REQ   = M0_REQ;
        S_LOCK  = M0_LOCK;
        M0_BUSY = S_BUSY;
      end
      StOwn1: begin
        S_A     = M1_A;
        S_DO    = M1_DI;
        S_BA    = M1_BA;
        S_WE    = M1_WE;
        S_REQ   = M1_REQ;
        S_LOCK  = M1_LOCK;
        M1_BUSY = S_BUSY;
      end
      default: begin
      end
    endcase
  end

endmodule
